pipe_skid_register: RTL and testbench

PIPE_SKID_REGISTER -- requirements
Module: pipe_skid_register

---
 rtl/pipe_skid_pkg.sv | 23 ++
 rtl/pipe_skid_slot.sv | 57 +++++
 rtl/pipe_skid_register.sv | 174 +++++++++++++++++
 tb/tb_pipe_skid_register.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_pkg
//  Purpose  : Shared state encoding and default widths for the two-entry
//             pipeline skid register.
//  Contents : skid_state_t  - EMPTY / ONE (main valid) / FULL (main + skid)
//             c_DEFAULT_*   - default payload, control and counter widths
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_skid_pkg;

    localparam int unsigned c_DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned c_DEFAULT_CTRL_WIDTH = 4;
    localparam int unsigned c_STALL_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

endpackage : pipe_skid_pkg
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_slot
//  Purpose  : One storage entry (valid, control bundle, payload) with
//             synchronous load and clear.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             i_clear          - drop the entry (valid and control to zero,
//                                payload keeps its last value)
//             i_load           - capture i_ctrl / i_data and mark valid
//             o_valid/o_ctrl/o_data - registered entry contents
//  Priority : rst > i_clear > i_load
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_slot
    import pipe_skid_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = c_DEFAULT_CTRL_WIDTH,
    parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            // Control is squashed so a bubble never carries live control bits;
            // the payload is left alone to avoid needless toggling.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule : pipe_skid_slot
`default_nettype wire

// File: rtl/pipe_skid_register.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_register
//  Purpose  : Two-entry pipeline skid register. The main slot drives the
//             outputs; the skid slot absorbs one entry while downstream
//             stalls, so IN_READY is a pure register output.
//  Ports    : CLK, RESET (sync, active-high), FLUSH (sync squash)
//             BUSYWAIT                      - downstream stall
//             IN_VALID / IN_READY / IN_CTRL / IN_DATA     - upstream side
//             OUT_VALID / OUT_CTRL / OUT_DATA             - downstream side
//             STALL_COUNT                   - saturating stall-cycle counter
//  Macro    : PIPE_SKID_STATS_EN - adds STALL_COUNT port and counter
//  Priority : RESET > FLUSH > accept/consume
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_register
    import pipe_skid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = c_DEFAULT_CTRL_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         FLUSH,
    input  logic                         BUSYWAIT,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [CTRL_WIDTH-1:0]        IN_CTRL,
    input  logic [DATA_WIDTH-1:0]        IN_DATA,
    output logic                         OUT_VALID,
    output logic [CTRL_WIDTH-1:0]        OUT_CTRL,
`ifdef PIPE_SKID_STATS_EN
    output logic [c_STALL_CNT_WIDTH-1:0] STALL_COUNT,
`endif
    output logic [DATA_WIDTH-1:0]        OUT_DATA
);

    skid_state_t           r_state;
    skid_state_t           w_state_next;

    logic                  w_main_valid;
    logic [CTRL_WIDTH-1:0] w_main_ctrl;
    logic [DATA_WIDTH-1:0] w_main_data;
    logic                  w_skid_valid;
    logic [CTRL_WIDTH-1:0] w_skid_ctrl;
    logic [DATA_WIDTH-1:0] w_skid_data;

    logic                  w_accept;
    logic                  w_consume;
    logic                  w_main_load;
    logic                  w_main_clear;
    logic                  w_main_from_skid;
    logic                  w_skid_load;
    logic                  w_skid_clear;
    logic [CTRL_WIDTH-1:0] w_main_ctrl_in;
    logic [DATA_WIDTH-1:0] w_main_data_in;

    // Ready comes straight from the skid valid flop: no path from BUSYWAIT.
    assign IN_READY  = ~w_skid_valid;
    assign w_accept  = IN_VALID & IN_READY;
    assign w_consume = w_main_valid & ~BUSYWAIT;

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (FLUSH) begin
            w_state_next = EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_load  = 1'b1;
                        w_state_next = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_load  = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load  = 1'b1;
                        w_state_next = FULL;
                    end else if (w_consume) begin
                        w_main_clear = 1'b1;
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is older than anything upstream, so it
                    // is the only legal source for the main slot here.
                    if (w_consume) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_next     = ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : IN_CTRL;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : IN_DATA;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    pipe_skid_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_main_slot (
        .clk     (CLK),
        .rst     (RESET),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_skid_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_slot (
        .clk     (CLK),
        .rst     (RESET),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_ctrl  (IN_CTRL),
        .i_data  (IN_DATA),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    assign OUT_VALID = w_main_valid;
    assign OUT_CTRL  = w_main_ctrl;
    assign OUT_DATA  = w_main_data;

`ifdef PIPE_SKID_STATS_EN
    logic [c_STALL_CNT_WIDTH-1:0] r_stall_count;

    // Counts every cycle a valid head is held off; FLUSH deliberately does
    // not clear it so statistics survive pipeline squashes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_count <= '0;
        end else if (w_main_valid && BUSYWAIT && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign STALL_COUNT = r_stall_count;
`endif

endmodule : pipe_skid_register
`default_nettype wire

// File: tb/tb_pipe_skid_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_skid_register
//  Purpose  : Self-checking bench for pipe_skid_register. Accepted entries
//             are queued as expected output; consumed entries are popped and
//             compared. Scenario tasks add their own direct checks.
//  Macro    : PIPE_SKID_STATS_EN - also exercises STALL_COUNT
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_register;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          FLUSH;
    logic          BUSYWAIT;
    logic          IN_VALID;
    logic          IN_READY;
    logic [CW-1:0] IN_CTRL;
    logic [DW-1:0] IN_DATA;
    logic          OUT_VALID;
    logic [CW-1:0] OUT_CTRL;
    logic [DW-1:0] OUT_DATA;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0]   STALL_COUNT;
`endif

    int            vectors = 0;
    int            errors  = 0;
    bit            mon_on  = 1'b0;
    logic [CW+DW-1:0] sb_q[$];

    always #5 CLK = ~CLK;

    pipe_skid_register #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .BUSYWAIT    (BUSYWAIT),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_CTRL     (IN_CTRL),
        .IN_DATA     (IN_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_CTRL    (OUT_CTRL),
`ifdef PIPE_SKID_STATS_EN
        .STALL_COUNT (STALL_COUNT),
`endif
        .OUT_DATA    (OUT_DATA)
    );

    // Scoreboard monitor: looks at the inputs that the next rising edge will
    // see. Consume is checked before push because the head is always older.
    always @(negedge CLK) begin
        if (mon_on) begin
            if (RESET || FLUSH) begin
                sb_q.delete();
            end else begin
                vectors++;
                if (!OUT_VALID && OUT_CTRL !== '0) begin
                    errors++;
                    $display("FAIL bubble_ctrl: got %h want 0", OUT_CTRL);
                end
                if (OUT_VALID && !BUSYWAIT) begin
                    vectors++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: got ctrl=%h data=%0d want nothing",
                                 OUT_CTRL, OUT_DATA);
                    end else begin
                        logic [CW+DW-1:0] exp;
                        exp = sb_q.pop_front();
                        if ({OUT_CTRL, OUT_DATA} !== exp) begin
                            errors++;
                            $display("FAIL sb_order: got ctrl=%h data=%0d want ctrl=%h data=%0d",
                                     OUT_CTRL, OUT_DATA, exp[CW+DW-1:DW], exp[DW-1:0]);
                        end
                    end
                end
                if (IN_VALID && IN_READY) begin
                    sb_q.push_back({IN_CTRL, IN_DATA});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
        IN_VALID = 1'b1;
        IN_CTRL  = c;
        IN_DATA  = d;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 1'b1; IN_CTRL = 4'hF; IN_DATA = 159;
        tick();
        RESET = 1'b0; IN_VALID = 1'b0;
        mon_on = 1'b1;
        vectors++;
        if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OUT_DATA !== '0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b c=%h d=%0d rdy=%b want v=0 c=0 d=0 rdy=1",
                     OUT_VALID, OUT_CTRL, OUT_DATA, IN_READY);
        end
    endtask

    task automatic test_single_pass();
        BUSYWAIT = 1'b0;
        offer(4'hF, 159);
        tick();
        IN_VALID = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b1 || OUT_CTRL !== 4'hF || OUT_DATA !== 159) begin
            errors++;
            $display("FAIL single_pass: got v=%b c=%h d=%0d want v=1 c=f d=159",
                     OUT_VALID, OUT_CTRL, OUT_DATA);
        end
        tick();
        vectors++;
        if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OUT_DATA !== 159) begin
            errors++;
            $display("FAIL single_drain: got v=%b c=%h d=%0d want v=0 c=0 d=159",
                     OUT_VALID, OUT_CTRL, OUT_DATA);
        end
    endtask

    // Leaves the block FULL with 159 at the head and 19 in the skid slot.
    task automatic fill_full();
        BUSYWAIT = 1'b1;
        offer(4'hF, 159);
        tick();
        offer(4'h3, 19);
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic test_skid();
        fill_full();
        repeat (2) begin
            vectors++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 159 || OUT_CTRL !== 4'hF || IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL skid_hold: got v=%b c=%h d=%0d rdy=%b want v=1 c=f d=159 rdy=0",
                         OUT_VALID, OUT_CTRL, OUT_DATA, IN_READY);
            end
            tick();
        end
        BUSYWAIT = 1'b0;
        tick();
        vectors++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 19 || OUT_CTRL !== 4'h3 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL skid_release: got v=%b c=%h d=%0d rdy=%b want v=1 c=3 d=19 rdy=1",
                     OUT_VALID, OUT_CTRL, OUT_DATA, IN_READY);
        end
        tick();
        vectors++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL skid_drain: got v=%b want v=0", OUT_VALID);
        end
    endtask

    task automatic test_flush();
        fill_full();
        FLUSH = 1'b1;
        offer(4'h5, 80);
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got v=%b c=%h rdy=%b want v=0 c=0 rdy=1",
                     OUT_VALID, OUT_CTRL, IN_READY);
        end
        BUSYWAIT = 1'b0;
        repeat (3) begin
            tick();
            vectors++;
            if (OUT_VALID !== 1'b0 || OUT_DATA === 80) begin
                errors++;
                $display("FAIL flush_leak: got v=%b d=%0d want v=0 d!=80", OUT_VALID, OUT_DATA);
            end
        end
    endtask

    task automatic test_back_to_back();
        BUSYWAIT = 1'b0;
        for (int i = 0; i < 100; i++) begin
            logic [DW-1:0] d;
            d = DW'(i);
            offer(d[CW-1:0], d);
            vectors++;
            if (IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: got %b want 1 at i=%0d", IN_READY, i);
            end
            tick();
            vectors++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== d) begin
                errors++;
                $display("FAIL stream_out: got v=%b d=%0d want v=1 d=%0d", OUT_VALID, OUT_DATA, d);
            end
        end
        IN_VALID = 1'b0;
        tick();
        tick();
        vectors++;
        if (sb_q.size() != 0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got pending=%0d v=%b want pending=0 v=0",
                     sb_q.size(), OUT_VALID);
        end
    endtask

    task automatic test_reset_mid_stall();
        fill_full();
        RESET = 1'b1;
        BUSYWAIT = 1'b0;
        tick();
        RESET = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OUT_DATA !== '0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got v=%b c=%h d=%0d rdy=%b want v=0 c=0 d=0 rdy=1",
                     OUT_VALID, OUT_CTRL, OUT_DATA, IN_READY);
        end
        tick();
        vectors++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== '0) begin
            errors++;
            $display("FAIL reset_stall_leak: got v=%b d=%0d want v=0 d=0", OUT_VALID, OUT_DATA);
        end
    endtask

`ifdef PIPE_SKID_STATS_EN
    task automatic test_stats();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        BUSYWAIT = 1'b1;
        offer(4'h1, 7);
        tick();
        IN_VALID = 1'b0;
        repeat (10) tick();
        vectors++;
        if (STALL_COUNT !== 16'd10) begin
            errors++;
            $display("FAIL stats_count: got %0d want 10", STALL_COUNT);
        end
        repeat (69990) tick();
        vectors++;
        if (STALL_COUNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_sat: got %h want ffff", STALL_COUNT);
        end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        vectors++;
        if (STALL_COUNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_flush: got %h want ffff", STALL_COUNT);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        BUSYWAIT = 1'b0;
        vectors++;
        if (STALL_COUNT !== 16'h0000) begin
            errors++;
            $display("FAIL stats_reset: got %h want 0", STALL_COUNT);
        end
    endtask
`endif

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; BUSYWAIT = 1'b0;
        IN_VALID = 1'b0; IN_CTRL = '0; IN_DATA = '0;
        test_reset();
        test_single_pass();
        test_skid();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef PIPE_SKID_STATS_EN
        test_stats();
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_pipe_skid_register
`default_nettype wire
